// File: rtl/game_pkg.sv
// Shared definitions for the sequence game: sizes, FSM states and the sequence ROM.
package game_pkg;

    localparam int unsigned SEQ_LEN = 10;
    localparam int unsigned DATA_W  = 4;
    localparam int unsigned LEVEL_W = 4;
    localparam int unsigned IDX_W   = $clog2(SEQ_LEN);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SHOW = 2'd1,
        ST_GAP  = 2'd2,
        ST_DONE = 2'd3
    } seq_state_e;

    // Sequence ROM entry: (13*i + 46) mod 16
    function automatic logic [DATA_W-1:0] seq_entry(input logic [IDX_W-1:0] i);
        logic [7:0] v;
        v = 8'd13 * 8'(i) + 8'd46;
        return DATA_W'(v % 8'd16);
    endfunction

    // Clamp a requested level to the last valid sequence index
    function automatic logic [IDX_W-1:0] clamp_level(input logic [LEVEL_W-1:0] lvl);
        if (32'(lvl) > SEQ_LEN - 1)
            return IDX_W'(SEQ_LEN - 1);
        else
            return IDX_W'(lvl);
    endfunction

endpackage

// File: rtl/sequence_presenter_if.sv
// Control/display bundle of the sequence presenter.
// The abort signal exists only when SEQ_ABORT_EN is defined.
interface sequence_presenter_if;
    import game_pkg::*;

    logic                start;
    logic [LEVEL_W-1:0]  level;
    logic                busy;
    logic                done;
    logic                led_valid;
    logic [DATA_W-1:0]   led_data;
`ifdef SEQ_ABORT_EN
    logic                abort;

    modport master (output start, level, abort, input busy, done, led_valid, led_data);
    modport slave  (input start, level, abort, output busy, done, led_valid, led_data);
`else
    modport master (output start, level, input busy, done, led_valid, led_data);
    modport slave  (input start, level, output busy, done, led_valid, led_data);
`endif

endinterface

// File: rtl/dwell_timer.sv
// Loadable down-counter: load sets the count, count enables decrement, stops at zero.
module dwell_timer #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             i_load,
    input  logic             i_count,
    input  logic [WIDTH-1:0] i_load_val,
    output logic             o_expired_c
);

    logic [WIDTH-1:0] r_count;

    // Load has priority over decrement; the counter saturates at zero
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_count <= '0;
        end else if (i_load) begin
            r_count <= i_load_val;
        end else if (i_count && (r_count != '0)) begin
            r_count <= r_count - WIDTH'(1);
        end
    end

    assign o_expired_c = (r_count == '0);

endmodule

// File: rtl/sequence_presenter.sv
// Plays ROM entries 0..level on the LED outputs with timed on/off dwell, then pulses done.
// Optional feature macro: SEQ_ABORT_EN (adds an abort input that cancels playback).
module sequence_presenter
    import game_pkg::*;
#(
    parameter int unsigned ON_CYCLES  = 50_000_000,
    parameter int unsigned OFF_CYCLES = 25_000_000
) (
    input  logic                 clk,
    input  logic                 reset,
    sequence_presenter_if.slave  bus
);

    localparam int unsigned MAX_DWELL = (ON_CYCLES > OFF_CYCLES) ? ON_CYCLES : OFF_CYCLES;
    localparam int unsigned TIMER_W   = $clog2(MAX_DWELL + 1);

    seq_state_e          r_state;
    logic [IDX_W-1:0]    r_idx;
    logic [IDX_W-1:0]    r_last;
    logic                r_busy;
    logic                r_done;
    logic                r_led_valid;
    logic [DATA_W-1:0]   r_led_data;

    logic                w_start;
    logic                w_abort;
    logic                w_expired;
    logic                w_load;
    logic                w_count;
    logic [TIMER_W-1:0]  w_load_val;

    assign w_start = bus.start;
`ifdef SEQ_ABORT_EN
    assign w_abort = bus.abort;
`else
    assign w_abort = 1'b0;
`endif

    // Timer reloads whenever SHOW or GAP is (re)entered; each dwell lasts load value + 1 cycles
    assign w_load = ((r_state == ST_IDLE) && w_start) ||
                    ((r_state == ST_SHOW) && w_expired && !w_abort) ||
                    ((r_state == ST_GAP)  && w_expired && !w_abort && (r_idx != r_last));
    assign w_load_val = (r_state == ST_SHOW) ? TIMER_W'(OFF_CYCLES - 1) : TIMER_W'(ON_CYCLES - 1);
    assign w_count    = (r_state == ST_SHOW) || (r_state == ST_GAP);

    dwell_timer #(
        .WIDTH (TIMER_W)
    ) u_dwell_timer (
        .clk         (clk),
        .reset       (reset),
        .i_load      (w_load),
        .i_count     (w_count),
        .i_load_val  (w_load_val),
        .o_expired_c (w_expired)
    );

    // Playback FSM with registered outputs; abort wins over timer expiry
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state     <= ST_IDLE;
            r_idx       <= '0;
            r_last      <= '0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_led_valid <= 1'b0;
            r_led_data  <= '0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (w_start) begin
                        r_last      <= clamp_level(bus.level);
                        r_idx       <= '0;
                        r_state     <= ST_SHOW;
                        r_busy      <= 1'b1;
                        r_led_valid <= 1'b1;
                        r_led_data  <= seq_entry('0);
                    end
                end
                ST_SHOW: begin
                    if (w_abort) begin
                        r_state     <= ST_DONE;
                        r_done      <= 1'b1;
                        r_led_valid <= 1'b0;
                        r_led_data  <= '0;
                    end else if (w_expired) begin
                        r_state     <= ST_GAP;
                        r_led_valid <= 1'b0;
                        r_led_data  <= '0;
                    end
                end
                ST_GAP: begin
                    if (w_abort || (w_expired && (r_idx == r_last))) begin
                        r_state     <= ST_DONE;
                        r_done      <= 1'b1;
                        r_led_valid <= 1'b0;
                        r_led_data  <= '0;
                    end else if (w_expired) begin
                        r_idx       <= r_idx + IDX_W'(1);
                        r_state     <= ST_SHOW;
                        r_led_valid <= 1'b1;
                        r_led_data  <= seq_entry(r_idx + IDX_W'(1));
                    end
                end
                ST_DONE: begin
                    r_state <= ST_IDLE;
                    r_busy  <= 1'b0;
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.busy      = r_busy;
    assign bus.done      = r_done;
    assign bus.led_valid = r_led_valid;
    assign bus.led_data  = r_led_data;

endmodule

// File: tb/tb_sequence_presenter.sv
// Scoreboard bench for sequence_presenter with ON_CYCLES=3, OFF_CYCLES=2.
// Each accepted start pushes the expected per-cycle output trace; a negedge monitor pops and compares.
module tb_sequence_presenter;

    localparam int ON  = 3;
    localparam int OFF = 2;

    logic clk;
    logic reset;

    sequence_presenter_if bus();

    sequence_presenter #(
        .ON_CYCLES  (ON),
        .OFF_CYCLES (OFF)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int n_checks = 0;
    int n_errors = 0;

    // {busy, done, led_valid, led_data}
    logic [6:0] sb[$];
    int rom[10] = '{14, 11, 8, 5, 2, 15, 12, 9, 6, 3};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic logic [6:0] mk(input bit b, input bit d, input bit v, input int data);
        return {b, d, v, 4'(data)};
    endfunction

    // Expected trace from the cycle start is asserted until back in idle
    function automatic void push_run(input int lvl);
        int last;
        last = (lvl > 9) ? 9 : lvl;
        sb.push_back(mk(0, 0, 0, 0));
        for (int e = 0; e <= last; e++) begin
            for (int c = 0; c < ON; c++)  sb.push_back(mk(1, 0, 1, rom[e]));
            for (int c = 0; c < OFF; c++) sb.push_back(mk(1, 0, 0, 0));
        end
        sb.push_back(mk(1, 1, 0, 0));
        sb.push_back(mk(0, 0, 0, 0));
    endfunction

    always @(negedge clk) begin
        if (sb.size() > 0) begin
            logic [6:0] exp_v;
            exp_v = sb.pop_front();
            chk("trace", {25'd0, bus.busy, bus.done, bus.led_valid, bus.led_data}, {25'd0, exp_v});
        end
    end

    // Start pulse in cycle 0; returns one cycle later, just after the edge
    task automatic issue_start(input int lvl, input bit do_push);
        @(posedge clk); #1;
        bus.start = 1'b1;
        bus.level = 4'(lvl);
        if (do_push) push_run(lvl);
        @(posedge clk); #1;
        bus.start = 1'b0;
    endtask

    task automatic wait_drain(input int budget);
        int n;
        n = 0;
        while (sb.size() != 0 && n < budget) begin
            @(posedge clk);
            n++;
        end
        if (sb.size() != 0) begin
            chk("drain_timeout", 32'(sb.size()), 32'd0);
            sb.delete();
        end
        repeat (2) @(posedge clk);
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_busy"},  32'(bus.busy),      32'd0);
        chk({tag, "_done"},  32'(bus.done),      32'd0);
        chk({tag, "_valid"}, 32'(bus.led_valid), 32'd0);
        chk({tag, "_data"},  32'(bus.led_data),  32'd0);
    endtask

    initial begin
        reset     = 1'b1;
        bus.start = 1'b0;
        bus.level = '0;
`ifdef SEQ_ABORT_EN
        bus.abort = 1'b0;
`endif
        repeat (3) @(posedge clk);
        #1;
        chk_all_zero("reset");
        reset = 1'b0;
        repeat (2) @(posedge clk);

        // 1: single entry
        issue_start(0, 1'b1);
        wait_drain(100);

        // 2: three entries
        issue_start(2, 1'b1);
        wait_drain(100);

        // 3: level clamped to 9
        issue_start(12, 1'b1);
        wait_drain(200);

        // 4: second start and level change at cycle 4 are ignored
        issue_start(1, 1'b1);
        repeat (3) @(posedge clk);
        #1;
        bus.start = 1'b1;
        bus.level = 4'd5;
        @(posedge clk); #1;
        bus.start = 1'b0;
        wait_drain(100);

        // 5: reset during the gap of entry 1 (cycle 9 of a level=2 run)
        issue_start(2, 1'b1);
        repeat (8) @(posedge clk);
        #1;
        sb.delete();
        reset = 1'b1;
        #1;
        chk_all_zero("midrst");
        @(posedge clk); #1;
        reset = 1'b0;
        repeat (2) @(posedge clk);
        issue_start(0, 1'b1);
        wait_drain(100);

`ifdef SEQ_ABORT_EN
        // 6: abort in SHOW cycle 2 of entry 0
        sb.push_back(mk(0, 0, 0, 0));
        sb.push_back(mk(1, 0, 1, 14));
        sb.push_back(mk(1, 0, 1, 14));
        sb.push_back(mk(1, 1, 0, 0));
        sb.push_back(mk(0, 0, 0, 0));
        issue_start(3, 1'b0);
        @(posedge clk); #1;
        bus.abort = 1'b1;
        @(posedge clk); #1;
        bus.abort = 1'b0;
        wait_drain(100);

        // start and abort together in idle: start wins
        @(posedge clk); #1;
        bus.abort = 1'b1;
        bus.start = 1'b1;
        bus.level = 4'd0;
        push_run(0);
        @(posedge clk); #1;
        bus.start = 1'b0;
        bus.abort = 1'b0;
        wait_drain(100);
`endif

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
